// File: rtl/tdm_mux_4to1.sv
// Round-robin 4-to-1 time-division multiplexer with per-channel masking,
// programmable dwell per slot, a registered sample output and a frame marker.
module tdm_mux_4to1 #(
    parameter int DWELL = 1,
    parameter int CW    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       EN,
    input  logic [3:0] MASK,
    input  logic       D0,
    input  logic       D1,
    input  logic       D2,
    input  logic       D3,
    output logic       S1,
    output logic       S0,
    output logic       OUT,
    output logic       VALID,
    output logic       FRAME
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam logic [CW-1:0] LAST_CNT = CW'(DWELL - 1);

    state_t          state_r, state_s;
    logic [1:0]      sel_r, sel_s;
    logic [CW-1:0]   cnt_r, cnt_s;
    logic            out_r, out_s;
    logic            valid_r, valid_s;
    logic            frame_r, frame_s;
    logic [3:0]      d_vec_s;

    function automatic logic [1:0] lowest_enabled(input logic [3:0] mask);
        logic [1:0] idx;
        casez (mask)
            4'b???1: idx = 2'd0;
            4'b??10: idx = 2'd1;
            4'b?100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Scan forward from cur; the smallest positive offset wins, offset 4 is cur itself.
    function automatic logic [1:0] next_enabled(input logic [1:0] cur, input logic [3:0] mask);
        logic [1:0] idx;
        logic [1:0] pick;
        pick = cur;
        for (int i = 3; i >= 1; i--) begin
            idx = cur + 2'(i);
            if (mask[idx]) begin
                pick = idx;
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

    assign d_vec_s = {D3, D2, D1, D0};

    // Next-state, slot sequencing and output sample computation.
    always_comb begin
        state_s = state_r;
        sel_s   = sel_r;
        cnt_s   = cnt_r;
        out_s   = out_r;
        valid_s = valid_r;
        frame_s = frame_r;
        case (state_r)
            IDLE: begin
                if (EN && (MASK != 4'b0000)) begin
                    state_s = SCAN;
                    sel_s   = lowest_enabled(MASK);
                    cnt_s   = '0;
                end else begin
                    sel_s   = 2'd0;
                    cnt_s   = '0;
                    valid_s = 1'b0;
                    frame_s = 1'b0;
                end
            end
            SCAN: begin
                if (!EN || (MASK == 4'b0000)) begin
                    state_s = IDLE;
                    sel_s   = 2'd0;
                    cnt_s   = '0;
                    valid_s = 1'b0;
                    frame_s = 1'b0;
                end else begin
                    out_s   = d_vec_s[sel_r];
                    valid_s = 1'b1;
                    frame_s = (sel_r == lowest_enabled(MASK)) && (cnt_r == '0);
                    // The slot always runs its full dwell; MASK only steers the advance.
                    if (cnt_r == LAST_CNT) begin
                        cnt_s = '0;
                        sel_s = next_enabled(sel_r, MASK);
                    end else begin
                        cnt_s = cnt_r + CW'(1);
                    end
                end
            end
            default: begin
                state_s = IDLE;
                sel_s   = 2'd0;
                cnt_s   = '0;
                out_s   = 1'b0;
                valid_s = 1'b0;
                frame_s = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            sel_r   <= 2'd0;
            cnt_r   <= '0;
            out_r   <= 1'b0;
            valid_r <= 1'b0;
            frame_r <= 1'b0;
        end else begin
            state_r <= state_s;
            sel_r   <= sel_s;
            cnt_r   <= cnt_s;
            out_r   <= out_s;
            valid_r <= valid_s;
            frame_r <= frame_s;
        end
    end

    assign S1    = sel_r[1];
    assign S0    = sel_r[0];
    assign OUT   = out_r;
    assign VALID = valid_r;
    assign FRAME = frame_r;

endmodule
